// File: rtl/strategy2_output_serializer.sv
// Captures one block of LANES combined results in a single cycle and streams it out
// one lane per beat, with incrementing wrapped addresses, toward the output buffer SRAM.
module strategy2_output_serializer #(
  parameter int LANES  = 16,
  parameter int LANE_W = 128,
  parameter int ADDR_W = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [LANES*LANE_W-1:0] i_result_flat,
  input  logic [ADDR_W-1:0]       i_base_addr,
  output logic                    o_wr_valid,
  input  logic                    i_wr_ready,
  output logic [LANE_W-1:0]       o_wr_data,
  output logic [ADDR_W-1:0]       o_wr_addr,
  output logic                    o_wr_last,
  output logic                    o_done,
  output logic                    o_busy
);

  localparam int CW = $clog2(LANES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state;
  logic [CW-1:0]           lane_cnt;
  logic [CW-1:0]           lane_nxt;
  logic [LANES*LANE_W-1:0] cap_buf;
  logic [ADDR_W-1:0]       base_q;
  logic                    last_lane;
  logic                    wr_fire;

  assign lane_nxt  = lane_cnt + CW'(1);
  assign last_lane = (lane_cnt == CW'(LANES - 1));
  assign wr_fire   = o_wr_valid & i_wr_ready;

  // The write outputs are preloaded one beat ahead so they stay registered and
  // simply hold across any number of stall cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      lane_cnt   <= '0;
      cap_buf    <= '0;
      base_q     <= '0;
      o_ready    <= 1'b1;
      o_wr_valid <= 1'b0;
      o_wr_data  <= '0;
      o_wr_addr  <= '0;
      o_wr_last  <= 1'b0;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            cap_buf    <= i_result_flat;
            base_q     <= i_base_addr;
            lane_cnt   <= '0;
            o_wr_data  <= i_result_flat[LANE_W-1:0];
            o_wr_addr  <= i_base_addr;
            o_wr_last  <= 1'b0;
            o_wr_valid <= 1'b1;
            o_busy     <= 1'b1;
            o_ready    <= 1'b0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (wr_fire) begin
            if (last_lane) begin
              lane_cnt   <= '0;
              o_wr_valid <= 1'b0;
              o_wr_last  <= 1'b0;
              o_busy     <= 1'b0;
              o_ready    <= 1'b1;
              o_done     <= 1'b1;
              state      <= IDLE;
            end else begin
              lane_cnt  <= lane_nxt;
              o_wr_data <= cap_buf[int'(lane_nxt)*LANE_W +: LANE_W];
              o_wr_addr <= base_q + ADDR_W'(lane_nxt);
              o_wr_last <= (lane_nxt == CW'(LANES - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/strategy2_output_serializer.md
Name: strategy2_output_serializer

Overview:
- Sits directly downstream of the strategy-2 output combiner.
- Captures one block of 16 combined 128-bit results in a single cycle.
- Writes the block out one lane per cycle over a valid/ready write port, with incrementing addresses, toward the output buffer SRAM.
- Decouples the wide parallel combiner output from the narrow buffer write path.

Parameters:
- LANES, 16, number of 128-bit result lanes per block.
- LANE_W, 128, width of one combined lane in bits.
- ADDR_W, 10, write address width; addresses wrap modulo 2^ADDR_W.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_valid  input  1  a block is present on i_result_flat.
- o_ready  output  1  block accepted on a cycle where i_valid and o_ready are both high.
- i_result_flat  input  LANES*LANE_W  lane k occupies bits [k*LANE_W +: LANE_W]; lane 0 is o_result_0_for_strategy2.
- i_base_addr  input  ADDR_W  write address of lane 0; sampled at acceptance.
- o_wr_valid  output  1  write beat valid.
- i_wr_ready  input  1  downstream accepts the beat.
- o_wr_data  output  LANE_W  lane data for the current beat.
- o_wr_addr  output  ADDR_W  base + lane index, modulo 2^ADDR_W.
- o_wr_last  output  1  high on the beat carrying lane LANES-1.
- o_done  output  1  one-cycle pulse after the final beat handshake.
- o_busy  output  1  high while in SEND.

Behaviour:
- Reset values: state=IDLE, lane counter=0, capture buffer=0, base register=0. Outputs o_wr_valid=0, o_wr_data=0, o_wr_addr=0, o_wr_last=0, o_done=0, o_busy=0. o_ready=1 in the first cycle after reset deasserts.
- Reset mid-block: the block is abandoned. No further beats are issued and no o_done is produced.
- State IDLE:
  - o_ready=1, o_wr_valid=0.
  - On i_valid & o_ready: register all LANES*LANE_W bits and i_base_addr, clear the counter, go to SEND.
- State SEND:
  - o_ready=0, o_busy=1, o_wr_valid=1.
  - o_wr_data=buffer lane[counter]; o_wr_addr=base+counter, truncated to ADDR_W; o_wr_last=(counter==LANES-1).
  - All write outputs are registered. They hold stable while o_wr_valid=1 and i_wr_ready=0, for any number of stall cycles.
  - On o_wr_valid & i_wr_ready with counter<LANES-1: counter increments, and the next lane appears the following cycle.
  - On o_wr_valid & i_wr_ready with counter==LANES-1: go to IDLE, and o_done=1 for exactly the next cycle.
- Latency and throughput:
  - The first beat is valid the cycle after acceptance.
  - With i_wr_ready held at 1, beats are back-to-back: LANES beats on consecutive cycles.
  - The next block can be accepted in the cycle o_done is high, giving a minimum block period of LANES+1 cycles.
- Boundaries and error handling:
  - i_valid while o_ready=0 is ignored. Upstream must hold i_valid and data until o_ready. Input data is never sampled outside the acceptance cycle, so changes during SEND have no effect.
  - Address wrap: base=2^ADDR_W-2 produces addresses 1022, 1023, 0, 1, … with no flag.
  - i_wr_ready high while o_wr_valid=0 has no effect.
- Simultaneous events:
  - i_rst has priority over every handshake.
  - When o_done=1 and i_valid=1 in the same cycle, the new block is accepted (state is IDLE).
- The counter width is clog2(LANES). LANES must be ≥2.

Test Plan:
- Reset then single block: lane k = {4{32'h0000_0100+k}}, base=0, i_wr_ready=1.
  - Acceptance at cycle T; beats at T+1..T+16 with addr 0..15 and data matching lane k.
  - o_wr_last only at T+16; o_done at T+17; o_ready high again at T+17.
- Backpressure: i_wr_ready pattern 1,0,0,1 repeating.
  - Data and address are unchanged across every stall.
  - All 16 lanes are delivered in order with no duplicates or drops.
  - o_done appears exactly once.
- Address wrap: base=10'd1020.
  - Addresses are 1020, 1021, 1022, 1023, 0, …, 11.
- Back-to-back blocks: hold i_valid=1 with a second block (lane k = 32'hA5A5_0000+k replicated) and base=16.
  - Second block accepted in the o_done cycle; its addresses run 16..31.
  - i_result_flat changes during SEND of block 1 do not corrupt block 1.
- Reset mid-block: assert i_rst after the 5th beat handshake.
  - All outputs return to reset values next cycle; no o_done.
  - A new block with base=100 after reset starts cleanly at lane 0, addr 100.
- i_valid during SEND (block 1 busy): no acceptance and o_ready stays 0; the held block is accepted at the first o_ready.
